sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one single-port, multi-cycle SRAM between the CPU's instruction-fetch port and its data (load/store) port, replacing separate instruction ROM and data RAM in the SOPC. It sits between `samming_cpu` and the external memory. It serializes accesses with a round-robin grant and drives the SRAM for a fixed number of wait cycles. It returns per-port ack pulses and asserts a stall request so the CPU pipeline holds while any request is outstanding.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width (1..30)
- WAIT_CYCLES, 1, extra SRAM cycles per access (0..15)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- inst_ce_i  in  1  fetch request; held until inst_ack_o
- inst_addr_i  in  32  fetch byte address
- inst_data_o  out  32  fetched word; valid in ack cycle, held until next inst ack
- inst_ack_o  out  1  one-cycle completion pulse, fetch port
- data_ce_i  in  1  data request; held until data_ack_o
- data_we_i  in  1  1 = store, 0 = load
- data_sel_i  in  4  byte enables, bit i = byte lane i
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  store data
- data_rdata_o  out  32  load word; valid in ack cycle, held until next data ack
- data_ack_o  out  1  one-cycle completion pulse, data port
- stallreq_o  out  1  pipeline hold request
- sram_ce_o  out  1  SRAM enable
- sram_we_o  out  1  SRAM write enable
- sram_be_o  out  4  SRAM byte enables
- sram_addr_o  out  ADDR_W  SRAM word address
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request pending: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the port not granted last. The last-grant flag resets to "inst", so data wins the first tie.
  - On grant: register the owner, addr, we, be and wdata. Load the wait counter with WAIT_CYCLES. Go to ACCESS.
- Registered access fields:
  - Fetch grant: we=0, be=4'b1111.
  - Data grant: we=data_we_i, be=data_sel_i.
  - sram_addr_o = byte address bits [ADDR_W+1:2]. Bits [1:0] and upper bits are ignored.
- ACCESS:
  - sram_ce_o=1. we/be/addr/wdata come from the registered fields.
  - Counter > 0: decrement and stay in ACCESS.
  - Counter = 0: capture sram_rdata_i into the owner's read register (fetch or load only; stores leave it unchanged), update the last-grant flag, go to ACK.
- ACK:
  - sram_ce_o=0, sram_we_o=0.
  - The owner's ack pulses high for exactly this cycle.
  - Next state is always IDLE.
- stallreq_o = (inst_ce_i & ~inst_ack_o) | (data_ce_i & ~data_ack_o). It is combinational and forced to 0 while rst=1.
- A granted access always runs to ACK, even if the requester drops ce mid-access. The non-owner port's signals are ignored until the next IDLE.
- Reset values (asynchronous, also on rst mid-access):
  - State IDLE.
  - All acks 0; sram_ce_o, sram_we_o = 0; sram_be_o = 0; sram_addr_o = 0; sram_wdata_o = 0.
  - inst_data_o, data_rdata_o = 0.
  - Last-grant = inst.
  - An aborted access produces no ack.

## Timing
- A request sampled in IDLE at edge N: ACCESS spans cycles N+1 .. N+1+WAIT_CYCLES, and ack is high in cycle N+2+WAIT_CYCLES.
- Per-access latency is WAIT_CYCLES+2 cycles from the sampling cycle.
- Issue interval is WAIT_CYCLES+3 cycles, including the IDLE sampling cycle.
- The SRAM sees ce high for exactly WAIT_CYCLES+1 consecutive cycles per access. rdata is sampled on the last of those cycles.
- A requester that sees ack may present a new request in the next cycle (IDLE). It is granted at that edge.
- With both ports continuously requesting, grants strictly alternate data, inst, data, ...

## Test plan
- WAIT_CYCLES=1, fetch only at 0x0000_0010, SRAM word 4 = 0x3401_0011 -> sram_addr_o=4 for 2 cycles. inst_ack_o pulses 3 cycles after the request cycle with inst_data_o=0x3401_0011. stallreq_o is 1 until the ack cycle.
- Store data_addr_i=0x0000_0104, sel=4'b0011, wdata=0xDEAD_BEEF -> sram_we_o=1, be=0011, addr=0x41, wdata=0xDEAD_BEEF. data_ack_o pulses. data_rdata_o is unchanged.
- Fetch and load both asserted from reset -> load granted first, fetch second. Acks are WAIT_CYCLES+3 cycles apart. Continued requests alternate grants.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 -> ce high for 1 and 4 cycles; acks at request cycle +2 and +5.
- rst asserted in the middle of ACCESS -> all outputs at reset values immediately (asynchronous), no ack. After release, a held request restarts from IDLE and completes normally.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one multi-cycle single-port SRAM between the
// CPU fetch port and the load/store port; raises a stall while any request is open.
module sram_port_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ce_i,
  input  logic [31:0]       inst_addr_i,
  output logic [31:0]       inst_data_o,
  output logic              inst_ack_o,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_sel_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic [31:0]       data_rdata_o,
  output logic              data_ack_o,
  output logic              stallreq_o,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_be_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t     state;
  logic       owner_data;
  logic       last_data;
  logic [3:0] wait_cnt;
  logic       grant_any;
  logic       grant_data;
  logic [63:0] unused_addr;

  // Only word-address bits reach the SRAM; byte offset and upper bits are dropped.
  assign unused_addr = {inst_addr_i, data_addr_i};

  // On a tie the port that was not served last wins.
  assign grant_any  = inst_ce_i | data_ce_i;
  assign grant_data = data_ce_i & (~inst_ce_i | ~last_data);

  assign stallreq_o = ~rst & ((inst_ce_i & ~inst_ack_o) | (data_ce_i & ~data_ack_o));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner_data   <= 1'b0;
      last_data    <= 1'b0;
      wait_cnt     <= 4'd0;
      inst_ack_o   <= 1'b0;
      data_ack_o   <= 1'b0;
      inst_data_o  <= 32'd0;
      data_rdata_o <= 32'd0;
      sram_ce_o    <= 1'b0;
      sram_we_o    <= 1'b0;
      sram_be_o    <= 4'd0;
      sram_addr_o  <= '0;
      sram_wdata_o <= 32'd0;
    end else begin
      inst_ack_o <= 1'b0;
      data_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_data <= grant_data;
            sram_ce_o  <= 1'b1;
            wait_cnt   <= 4'(WAIT_CYCLES);
            state      <= ACCESS;
            if (grant_data) begin
              sram_addr_o  <= data_addr_i[ADDR_W+1:2];
              sram_we_o    <= data_we_i;
              sram_be_o    <= data_sel_i;
              sram_wdata_o <= data_wdata_i;
            end else begin
              sram_addr_o  <= inst_addr_i[ADDR_W+1:2];
              sram_we_o    <= 1'b0;
              sram_be_o    <= 4'b1111;
              sram_wdata_o <= 32'd0;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            // Last enabled cycle: read data is valid now, close the access.
            sram_ce_o <= 1'b0;
            sram_we_o <= 1'b0;
            last_data <= owner_data;
            state     <= ACK;
            if (owner_data) begin
              data_ack_o <= 1'b1;
              if (!sram_we_o) data_rdata_o <= sram_rdata_i;
            end else begin
              inst_ack_o  <= 1'b1;
              inst_data_o <= sram_rdata_i;
            end
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: main instance at WAIT_CYCLES=1 with a
// byte-lane SRAM model, plus fetch-only instances at WAIT_CYCLES=0 and 3.
module tb_sram_port_arbiter;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic        inst_ce, data_ce, data_we;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_sel;
  logic [31:0] inst_data, data_rdata, sram_wdata, sram_rdata;
  logic        inst_ack, data_ack, stallreq, sram_ce, sram_we;
  logic [3:0]  sram_be;
  logic [19:0] sram_addr;

  // WAIT_CYCLES=0 and WAIT_CYCLES=3 instances (fetch only)
  logic        ce_w0, ce_w3;
  logic [31:0] inst_data_w0, inst_data_w3, data_rdata_w0, data_rdata_w3;
  logic [31:0] sram_wdata_w0, sram_wdata_w3, rdata_w0, rdata_w3;
  logic        ack_w0, ack_w3, dack_w0, dack_w3, stall_w0, stall_w3;
  logic        sram_ce_w0, sram_ce_w3, sram_we_w0, sram_we_w3;
  logic [3:0]  sram_be_w0, sram_be_w3;
  logic [19:0] sram_addr_w0, sram_addr_w3;

  sram_port_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce), .inst_addr_i(inst_addr), .inst_data_o(inst_data), .inst_ack_o(inst_ack),
    .data_ce_i(data_ce), .data_we_i(data_we), .data_sel_i(data_sel), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_ack_o(data_ack),
    .stallreq_o(stallreq), .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_be_o(sram_be),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  sram_port_arbiter #(.ADDR_W(20), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst),
    .inst_ce_i(ce_w0), .inst_addr_i(inst_addr), .inst_data_o(inst_data_w0), .inst_ack_o(ack_w0),
    .data_ce_i(1'b0), .data_we_i(1'b0), .data_sel_i(4'd0), .data_addr_i(32'd0),
    .data_wdata_i(32'd0), .data_rdata_o(data_rdata_w0), .data_ack_o(dack_w0),
    .stallreq_o(stall_w0), .sram_ce_o(sram_ce_w0), .sram_we_o(sram_we_w0), .sram_be_o(sram_be_w0),
    .sram_addr_o(sram_addr_w0), .sram_wdata_o(sram_wdata_w0), .sram_rdata_i(rdata_w0)
  );

  sram_port_arbiter #(.ADDR_W(20), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst),
    .inst_ce_i(ce_w3), .inst_addr_i(inst_addr), .inst_data_o(inst_data_w3), .inst_ack_o(ack_w3),
    .data_ce_i(1'b0), .data_we_i(1'b0), .data_sel_i(4'd0), .data_addr_i(32'd0),
    .data_wdata_i(32'd0), .data_rdata_o(data_rdata_w3), .data_ack_o(dack_w3),
    .stallreq_o(stall_w3), .sram_ce_o(sram_ce_w3), .sram_we_o(sram_we_w3), .sram_be_o(sram_be_w3),
    .sram_addr_o(sram_addr_w3), .sram_wdata_o(sram_wdata_w3), .sram_rdata_i(rdata_w3)
  );

  assign rdata_w0 = 32'hC0DE_0000 | {12'd0, sram_addr_w0};
  assign rdata_w3 = 32'hC0DE_0000 | {12'd0, sram_addr_w3};

  // SRAM model for the main instance: preload table plus byte-lane writes.
  logic [31:0] mem [0:255];
  logic        mem_valid [0:255];

  function automatic logic [31:0] preload(input logic [7:0] a);
    case (a)
      8'h04:   preload = 32'h3401_0011;
      8'h08:   preload = 32'h1122_3344;
      8'h41:   preload = 32'hAAAA_AAAA;
      default: preload = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    mem_word = (mem_valid[a] === 1'b1) ? mem[a] : preload(a);
  endfunction

  assign sram_rdata = mem_word(sram_addr[7:0]);

  always @(posedge clk) begin
    if (sram_ce && sram_we) begin
      logic [31:0] w;
      w = mem_word(sram_addr[7:0]);
      for (int b = 0; b < 4; b++)
        if (sram_be[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
      mem[sram_addr[7:0]]       <= w;
      mem_valid[sram_addr[7:0]] <= 1'b1;
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // fields the main SRAM bus carried during the last enabled cycle
  logic        seen_we;
  logic [3:0]  seen_be;
  logic [31:0] seen_addr, seen_wdata;

  // Called right after a request is driven on a negedge; counts negedges to ack,
  // then drops the request.  which: 0 main fetch, 1 main data, 2 w0 fetch, 3 w3 fetch.
  task automatic wait_ack(input int which, input int exp_lat, input string tag);
    int   n, ce_n;
    logic ack, ce, stall_ok;
    n = 0; ce_n = 0; ack = 1'b0; stall_ok = 1'b1;
    while (!ack && n < 30) begin
      @(negedge clk);
      n++;
      case (which)
        0:       begin ack = inst_ack; ce = sram_ce;    end
        1:       begin ack = data_ack; ce = sram_ce;    end
        2:       begin ack = ack_w0;   ce = sram_ce_w0; end
        default: begin ack = ack_w3;   ce = sram_ce_w3; end
      endcase
      if (ce) ce_n++;
      if (ce && which < 2) begin
        seen_we = sram_we; seen_be = sram_be;
        seen_addr = {12'd0, sram_addr}; seen_wdata = sram_wdata;
      end
      if (!ack && which < 2 && stallreq !== 1'b1) stall_ok = 1'b0;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_ce_cycles"}, ce_n, exp_lat - 1);
    if (which < 2) begin
      check({tag, "_stall_hold"}, stall_ok, 1'b1);
      check({tag, "_stall_ack"}, stallreq, 1'b0);
    end
    case (which)
      0:       inst_ce = 1'b0;
      1:       data_ce = 1'b0;
      2:       ce_w0 = 1'b0;
      default: ce_w3 = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   k;
    logic no_ack;
    rst = 1'b1;
    inst_ce = 1'b0; data_ce = 1'b0; data_we = 1'b0; ce_w0 = 1'b0; ce_w3 = 1'b0;
    inst_addr = 32'h0000_0010; data_addr = 32'd0; data_sel = 4'd0; data_wdata = 32'd0;
    for (int i = 0; i < 256; i++) mem_valid[i] = 1'b0;

    // reset values, request held during reset must not stall
    repeat (2) @(negedge clk);
    inst_ce = 1'b1;
    #1;
    check("rst_stall", stallreq, 1'b0);
    check("rst_bus", {sram_ce, sram_we, sram_be, sram_addr}, 32'd0);
    check("rst_wdata", sram_wdata, 32'd0);
    check("rst_acks", {inst_ack, data_ack}, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);
    inst_ce = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // fetch only at 0x10
    @(negedge clk);
    inst_ce = 1'b1; inst_addr = 32'h0000_0010;
    #1 check("fetch_stall_req", stallreq, 1'b1);
    wait_ack(0, 3, "fetch");
    check("fetch_addr", seen_addr, 32'h4);
    check("fetch_we_be", {seen_we, seen_be}, 32'h0F);
    check("fetch_data", inst_data, 32'h3401_0011);
    @(negedge clk);
    check("fetch_ack_pulse", inst_ack, 1'b0);

    // store 0xDEADBEEF to 0x104, lanes 0,1
    data_ce = 1'b1; data_we = 1'b1; data_sel = 4'b0011;
    data_addr = 32'h0000_0104; data_wdata = 32'hDEAD_BEEF;
    wait_ack(1, 3, "store");
    check("store_we_be", {seen_we, seen_be}, 32'h13);
    check("store_addr", seen_addr, 32'h41);
    check("store_wdata", seen_wdata, 32'hDEAD_BEEF);
    check("store_rdata_kept", data_rdata, 32'd0);
    @(negedge clk);
    check("store_ack_pulse", data_ack, 1'b0);
    check("store_mem", mem_word(8'h41), 32'hAAAA_BEEF);

    // load back the merged word
    data_ce = 1'b1; data_we = 1'b0; data_sel = 4'b1111;
    wait_ack(1, 3, "load");
    check("load_we_be", {seen_we, seen_be}, 32'h0F);
    check("load_rdata", data_rdata, 32'hAAAA_BEEF);
    @(negedge clk);

    // both ports requesting continuously from reset: data, inst, data, inst
    do_reset();
    inst_addr = 32'h0000_0010; data_addr = 32'h0000_0020; data_we = 1'b0;
    inst_ce = 1'b1; data_ce = 1'b1;
    exp_q.push_back({8'd1, 8'd3});
    exp_q.push_back({8'd0, 8'd7});
    exp_q.push_back({8'd1, 8'd11});
    exp_q.push_back({8'd0, 8'd15});
    for (k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (data_ack) begin
        if (exp_q.size() == 0) check("tie_order", {8'd1, 8'(k)}, 32'hFFFF);
        else check("tie_order", {8'd1, 8'(k)}, exp_q.pop_front());
        check("tie_load_data", data_rdata, 32'h1122_3344);
      end
      if (inst_ack) begin
        if (exp_q.size() == 0) check("tie_order", {8'd0, 8'(k)}, 32'hFFFF);
        else check("tie_order", {8'd0, 8'(k)}, exp_q.pop_front());
        check("tie_fetch_data", inst_data, 32'h3401_0011);
      end
    end
    inst_ce = 1'b0; data_ce = 1'b0;
    check("tie_all_acks", exp_q.size(), 0);
    repeat (4) @(negedge clk);

    // WAIT_CYCLES=0 and 3
    ce_w0 = 1'b1;
    wait_ack(2, 2, "w0");
    check("w0_data", inst_data_w0, 32'hC0DE_0004);
    @(negedge clk);
    ce_w3 = 1'b1;
    wait_ack(3, 5, "w3");
    check("w3_data", inst_data_w3, 32'hC0DE_0004);
    @(negedge clk);

    // asynchronous reset in the middle of ACCESS
    inst_ce = 1'b1;
    @(negedge clk);
    check("rm_in_access", sram_ce, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rm_bus", {sram_ce, sram_we, sram_be, sram_addr}, 32'd0);
    check("rm_inst_data", inst_data, 32'd0);
    check("rm_stall", stallreq, 1'b0);
    no_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (inst_ack || data_ack) no_ack = 1'b0;
    end
    check("rm_no_ack", no_ack, 1'b1);
    rst = 1'b0;
    wait_ack(0, 3, "rm_restart");
    check("rm_restart_data", inst_data, 32'h3401_0011);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
